// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bus: EX/MEM fields in, registered MEM/WB fields and write-back value out.
interface mem_wb_stage_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 3
);
  logic              enb;
  logic [DATA_W-1:0] IaluResult;
  logic [DATA_W-1:0] Ir2;
  logic [REG_W-1:0]  Idest;
  logic [REG_W-1:0]  IR2Address;
  logic              IDMMemWrite;
  logic              IregWrite;
  logic              IregWriteDataSel;
  logic [DATA_W-1:0] OmemData;
  logic [DATA_W-1:0] OaluResult;
  logic [REG_W-1:0]  Odest;
  logic              OregWrite;
  logic              OregWriteDataSel;
  logic [DATA_W-1:0] wbData;

  modport master (
    output enb, IaluResult, Ir2, Idest, IR2Address, IDMMemWrite, IregWrite, IregWriteDataSel,
    input  OmemData, OaluResult, Odest, OregWrite, OregWriteDataSel, wbData
  );

  modport slave (
    input  enb, IaluResult, Ir2, Idest, IR2Address, IDMMemWrite, IregWrite, IregWriteDataSel,
    output OmemData, OaluResult, Odest, OregWrite, OregWriteDataSel, wbData
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access stage: async-read / sync-write data memory with store-data forwarding
// from write-back, plus the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] store_data;
  logic              fwd;

  assign addr  = bus.IaluResult[ADDR_W-1:0];
  assign rdata = mem[addr];

  // Forwarding source is the MEM/WB register itself, so it stays stable through a stall.
  assign fwd        = bus.OregWrite && (bus.Odest == bus.IR2Address);
  assign store_data = fwd ? bus.wbData : bus.Ir2;

  assign bus.wbData = bus.OregWriteDataSel ? bus.OmemData : bus.OaluResult;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.OmemData         <= '0;
      bus.OaluResult       <= '0;
      bus.Odest            <= '0;
      bus.OregWrite        <= 1'b0;
      bus.OregWriteDataSel <= 1'b0;
    end else if (bus.enb) begin
      if (bus.IDMMemWrite) mem[addr] <= store_data;
      // rdata is sampled before the write lands: same-address read returns old contents.
      bus.OmemData         <= rdata;
      bus.OaluResult       <= bus.IaluResult;
      bus.Odest            <= bus.Idest;
      bus.OregWrite        <= bus.IregWrite;
      bus.OregWriteDataSel <= bus.IregWriteDataSel;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load/store, pass-through, forwarding, stall, reset mid-store.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mem_wb_stage_if #(.DATA_W(8), .ADDR_W(8), .REG_W(3)) bus ();

  mem_wb_stage #(.DATA_W(8), .ADDR_W(8), .REG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [7:0] alu, input logic [7:0] r2,
                       input logic [2:0] dst, input logic [2:0] r2a,
                       input logic we, input logic rw, input logic sel);
    bus.enb              = e;
    bus.IaluResult       = alu;
    bus.Ir2              = r2;
    bus.Idest            = dst;
    bus.IR2Address       = r2a;
    bus.IDMMemWrite      = we;
    bus.IregWrite        = rw;
    bus.IregWriteDataSel = sel;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".OmemData"},   32'(bus.OmemData),         32'h0);
    chk({tag, ".OaluResult"}, 32'(bus.OaluResult),       32'h0);
    chk({tag, ".Odest"},      32'(bus.Odest),            32'h0);
    chk({tag, ".OregWrite"},  32'(bus.OregWrite),        32'h0);
    chk({tag, ".OregSel"},    32'(bus.OregWriteDataSel), 32'h0);
    chk({tag, ".wbData"},     32'(bus.wbData),           32'h0);
  endtask

  initial begin
    // Reset for 2 cycles with a store pending: no store, outputs cleared
    rst = 1'b1;
    drive(1'b1, 8'h10, 8'h55, 3'd7, 3'd0, 1'b1, 1'b1, 1'b1);
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;

    drive(1'b1, 8'h10, 8'h00, 3'd1, 3'd6, 1'b0, 1'b1, 1'b1);
    step();
    chk("load_0x10_after_reset", 32'(bus.OmemData), 32'h00);
    chk("load_0x10_alu",         32'(bus.OaluResult), 32'h10);

    // Store 0xA5 to 0x3C; same-cycle read captures the old value
    drive(1'b1, 8'h3C, 8'hA5, 3'd0, 3'd6, 1'b1, 1'b0, 1'b0);
    step();
    chk("rdw_old_value", 32'(bus.OmemData), 32'h00);
    drive(1'b1, 8'h3C, 8'h00, 3'd5, 3'd6, 1'b0, 1'b1, 1'b1);
    step();
    chk("load_0x3C_data",  32'(bus.OmemData),  32'hA5);
    chk("load_0x3C_dest",  32'(bus.Odest),     32'd5);
    chk("load_0x3C_rw",    32'(bus.OregWrite), 32'd1);
    chk("load_0x3C_wb",    32'(bus.wbData),    32'hA5);

    // ALU pass-through
    drive(1'b1, 8'h7E, 8'h00, 3'd2, 3'd6, 1'b0, 1'b1, 1'b0);
    step();
    chk("alu_wb",      32'(bus.wbData),   32'h7E);
    chk("alu_memdata", 32'(bus.OmemData), 32'h00);
    chk("alu_dest",    32'(bus.Odest),    32'd2);

    // Forwarding hit: R3=0x99 in MEM/WB, store R3 to 0x20
    drive(1'b1, 8'h99, 8'h00, 3'd3, 3'd6, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'h20, 8'h11, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk("fwd_store_alu", 32'(bus.OaluResult), 32'h20);
    chk("fwd_store_rw",  32'(bus.OregWrite),  32'd0);
    drive(1'b1, 8'h20, 8'h00, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1);
    step();
    chk("fwd_hit_mem", 32'(bus.OmemData), 32'h99);

    // Forwarding miss: R3 in MEM/WB, store uses R4
    drive(1'b1, 8'h99, 8'h00, 3'd3, 3'd6, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b1, 8'h20, 8'h11, 3'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h20, 8'h00, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1);
    step();
    chk("fwd_miss_mem", 32'(bus.OmemData), 32'h11);

    // Stall 3 cycles with store 0x42 -> 0x08 pending
    drive(1'b0, 8'h08, 8'h42, 3'd4, 3'd6, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_alu",  32'(bus.OaluResult), 32'h20);
      chk("stall_mem",  32'(bus.OmemData),   32'h11);
      chk("stall_dest", 32'(bus.Odest),      32'd1);
      chk("stall_wb",   32'(bus.wbData),     32'h11);
    end
    bus.enb = 1'b1;
    step();
    chk("unstall_old_mem", 32'(bus.OmemData),   32'h00);
    chk("unstall_alu",     32'(bus.OaluResult), 32'h08);
    chk("unstall_dest",    32'(bus.Odest),      32'd4);
    drive(1'b1, 8'h08, 8'h00, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1);
    step();
    chk("stall_store_done", 32'(bus.OmemData), 32'h42);

    // Reset on the same edge as a store; earlier store also wiped
    drive(1'b1, 8'h02, 8'h33, 3'd0, 3'd6, 1'b1, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    drive(1'b1, 8'h01, 8'hFF, 3'd5, 3'd6, 1'b1, 1'b1, 1'b1);
    step();
    rst = 1'b0;
    chk_zero("midreset");
    drive(1'b1, 8'h01, 8'h00, 3'd1, 3'd6, 1'b0, 1'b0, 1'b1);
    step();
    chk("midreset_mem01", 32'(bus.OmemData), 32'h00);
    bus.IaluResult = 8'h02;
    step();
    chk("midreset_mem02", 32'(bus.OmemData), 32'h00);
    bus.IaluResult = 8'h3C;
    step();
    chk("midreset_mem3C", 32'(bus.OmemData), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
